// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit : multi-cycle multiply/divide unit with architectural HI/LO registers.
//
// Sits in EX beside the ALU. MULT/MULTU/DIV/DIVU hold Busy for a fixed number
// of cycles and then commit HI/LO in one shot; MTHI/MTLO write in a single
// cycle. Out is a plain read mux over HI/LO for MFHI/MFLO.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   Start    in   one-cycle launch pulse for the op on MDOp
//   MDOp     in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//                 11x reserved (ignored)
//   A, B     in   rs / rt operands (forwarded values)
//   HiLoSel  in   0: Out = LO, 1: Out = HI
//   Busy     out  registered; high while a mult/div is in flight
//   HI, LO   out  architectural HI / LO registers
//   Out      out  combinational HiLoSel ? HI : LO
// -----------------------------------------------------------------------------
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiLoSel,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] Out
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------ state
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [WIDTH-1:0] a_q,    a_d;
    logic [WIDTH-1:0] b_q,    b_d;
    // Latched op: bit1 = divide, bit0 = unsigned
    logic [1:0]       op_q,   op_d;
    logic [WIDTH-1:0] hi_q,   hi_d;
    logic [WIDTH-1:0] lo_q,   lo_d;

    // ------------------------------------------------------------ datapath
    logic                 is_div, is_sgn;
    logic                 a_neg, b_neg, b_zero;
    logic [2*WIDTH-1:0]   a_ext, b_ext, prod;
    logic [WIDTH-1:0]     mag_a, mag_b, div_den;
    logic [WIDTH-1:0]     uq, ur, quo, rem;

    assign is_div = op_q[1];
    assign is_sgn = ~op_q[0];
    assign a_neg  = is_sgn & a_q[WIDTH-1];
    assign b_neg  = is_sgn & b_q[WIDTH-1];
    assign b_zero = (b_q == '0);

    // One 2W x 2W multiplier covers both flavours: sign- or zero-extend the
    // operands to 2W and keep the low 2W bits of the product.
    assign a_ext = {{WIDTH{a_neg}}, a_q};
    assign b_ext = {{WIDTH{b_neg}}, b_q};
    assign prod  = a_ext * b_ext;

    // Signed divide via magnitudes. The overflow case (most negative / -1)
    // falls out naturally: |A| = 2^(W-1), |B| = 1, signs equal, so the
    // quotient is 2^(W-1) unnegated and the remainder is 0.
    assign mag_a   = a_neg ? (~a_q + WIDTH'(1)) : a_q;
    assign mag_b   = b_neg ? (~b_q + WIDTH'(1)) : b_q;
    // Keep the divider away from a zero denominator; the result is discarded
    // anyway when B is zero.
    assign div_den = b_zero ? WIDTH'(1) : mag_b;
    assign uq      = mag_a / div_den;
    assign ur      = mag_a % div_den;
    assign quo     = (a_neg ^ b_neg) ? (~uq + WIDTH'(1)) : uq;
    assign rem     = a_neg ? (~ur + WIDTH'(1)) : ur;

    // --------------------------------------------------------- next state
    logic start_ok;
    assign start_ok = Start & ~busy_q & ~(MDOp[2] & MDOp[1]);

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        hi_d   = hi_q;
        lo_d   = lo_q;

        if (busy_q) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                busy_d = 1'b0;
                if (!is_div) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (!b_zero) begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
        end else if (start_ok) begin
            case (MDOp)
                OP_MULT, OP_MULTU: begin
                    a_d    = A;
                    b_d    = B;
                    op_d   = MDOp[1:0];
                    cnt_d  = MULT_N;
                    busy_d = 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    a_d    = A;
                    b_d    = B;
                    op_d   = MDOp[1:0];
                    cnt_d  = DIV_N;
                    busy_d = 1'b1;
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    // -------------------------------------------------------------- outputs
    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
    // No bypass: MFHI/MFLO are held off in ID while a write is pending.
    assign Out  = HiLoSel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          Start;
    logic [2:0]    MDOp;
    logic [W-1:0]  A, B;
    logic          HiLoSel;
    logic          Busy;
    logic [W-1:0]  HI, LO, Out;

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .HiLoSel(HiLoSel), .Busy(Busy), .HI(HI), .LO(LO), .Out(Out)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge number E, cyc == E.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;   // edge after which HI/LO must hold the result
        bit          md;    // Busy expected high before due
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    bit          in_reset = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    int          busy_end = 0;   // last edge at which the unit is still busy

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs starting at a negedge; the reference model
    // decides acceptance and the architectural result with plain arithmetic.
    task automatic issue(input bit st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int          e;
        exp_t        x;
        longint      sa, sb, qq, rr;
        logic [63:0] ua, ub, p;
        Start   = st;
        MDOp    = op;
        A       = a;
        B       = b;
        HiLoSel = 1'($urandom_range(0, 1));
        e = cyc + 1;
        if (st && !(op[2] && op[1]) && e > busy_end) begin
            x.md  = !op[2];
            x.due = e;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            ua = {32'b0, a};
            ub = {32'b0, b};
            case (op)
                3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; x.due = e + MC; end
                3'd1: begin p = ua * ub;      m_hi = p[63:32]; m_lo = p[31:0]; x.due = e + MC; end
                3'd2: begin
                    if (b != 0) begin qq = sa / sb; rr = sa % sb; m_lo = qq[31:0]; m_hi = rr[31:0]; end
                    x.due = e + DC;
                end
                3'd3: begin
                    if (b != 0) begin m_lo = a / b; m_hi = a % b; end
                    x.due = e + DC;
                end
                3'd4: m_hi = a;
                default: m_lo = a;
            endcase
            if (x.md) busy_end = x.due;
            x.hi = m_hi;
            x.lo = m_lo;
            q.push_back(x);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        issue(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
    endtask

    task automatic idle_free();
        while (cyc + 1 <= busy_end) idle();
    endtask

    // Monitor: compares whenever the front expectation becomes due.
    always @(posedge clk) begin
        #1;
        if (!in_reset && q.size() > 0) begin
            if (cyc == q[0].due) begin
                chk("HI", HI, q[0].hi);
                chk("LO", LO, q[0].lo);
                chk("Busy_done", {31'b0, Busy}, 32'd0);
                chk("Out", Out, HiLoSel ? q[0].hi : q[0].lo);
                void'(q.pop_front());
            end else if (q[0].md) begin
                chk("Busy_run", {31'b0, Busy}, 32'd1);
            end
        end
    end

    initial begin
        int          t;
        logic [2:0]  op;
        logic [31:0] a, b;

        reset = 1'b0; Start = 1'b0; MDOp = '0; A = '0; B = '0; HiLoSel = 1'b0;
        #1;
        chk("rst_Busy", {31'b0, Busy}, 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        chk("rst_Out", Out, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Directed cases
        issue(1'b1, 3'd0, 32'hFFFFFFFE, 32'd3);            // MULT -2*3
        idle_free();
        issue(1'b1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);     // MULTU
        idle_free();
        issue(1'b1, 3'd2, 32'hFFFFFFF9, 32'd2);            // DIV -7/2
        idle_free();
        issue(1'b1, 3'd3, 32'd7, 32'd2);                   // DIVU 7/2
        idle_free();
        issue(1'b1, 3'd2, 32'h80000000, 32'hFFFFFFFF);     // DIV overflow
        idle_free();
        issue(1'b1, 3'd4, 32'h00001234, 32'd0);            // MTHI
        issue(1'b1, 3'd3, 32'd55, 32'd0);                  // DIVU by zero
        repeat (3) idle();
        issue(1'b1, 3'd0, 32'd9, 32'd9);                   // ignored mid-Busy
        idle_free();
        issue(1'b1, 3'd5, 32'hDEADBEEF, 32'd0);            // MTLO
        HiLoSel = 1'b0; #1 chk("Out_sel_lo", Out, 32'hDEADBEEF);
        HiLoSel = 1'b1; #1 chk("Out_sel_hi", Out, 32'h00001234);
        issue(1'b1, 3'd6, 32'h11111111, 32'd0);            // reserved
        issue(1'b1, 3'd7, 32'h22222222, 32'd0);            // reserved
        issue(1'b1, 3'd4, 32'hCAFEF00D, 32'd0);            // MTHI after reserved

        // Start in the cycle Busy falls is rejected, accepted one later
        issue(1'b1, 3'd1, 32'd1000, 32'd1000);
        while (cyc + 1 < busy_end) idle();
        issue(1'b1, 3'd4, 32'hAAAA5555, 32'd0);
        issue(1'b1, 3'd4, 32'h5555AAAA, 32'd0);

        // Random traffic
        repeat (400) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2, 3:    b = 32'($urandom_range(1, 17));
                default: b = $urandom;
            endcase
            issue($urandom_range(0, 1) == 1, op, a, b);
        end

        // Async reset mid-MULT aborts the operation
        idle_free();
        issue(1'b1, 3'd0, 32'h01234567, 32'h089ABCDE);
        idle();
        idle();
        @(posedge clk);
        #2;
        q.delete();
        in_reset = 1'b1;
        reset    = 1'b0;
        #1;
        chk("abort_Busy", {31'b0, Busy}, 32'd0);
        chk("abort_HI", HI, 32'd0);
        chk("abort_LO", LO, 32'd0);
        @(negedge clk);
        reset    = 1'b1;
        in_reset = 1'b0;
        m_hi     = '0;
        m_lo     = '0;
        busy_end = cyc;
        repeat (12) idle();
        chk("post_abort_HI", HI, 32'd0);
        chk("post_abort_LO", LO, 32'd0);
        chk("post_abort_Busy", {31'b0, Busy}, 32'd0);

        // A few ops after the abort to show the unit recovers
        issue(1'b1, 3'd3, 32'd100, 32'd7);
        idle_free();
        issue(1'b1, 3'd0, 32'h80000000, 32'h80000000);

        t = 0;
        while (q.size() > 0 && t < 50) begin
            idle();
            t++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations pending, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
